// File: rtl/stopwatch_pkg.sv
// Shared definitions for the stopwatch datapath: BCD digit width, digit
// moduli, and the 6-digit MM:SS.cc time record that is also consumed by the
// display stage.
package stopwatch_pkg;

   localparam int BCD_W        = 4;
   localparam int NUM_DIGITS   = 6;

   localparam int CS_MOD       = 10;
   localparam int UNITS_MOD    = 10;
   localparam int SEC_TENS_MOD = 6;
   localparam int MIN_TENS_MOD = 6;

   // Field order is MSB first, so a packed digit array indexed
   // [5:0] = {min_tens .. cs_units} casts directly onto this record.
   typedef struct packed {
      logic [BCD_W-1:0] min_tens;
      logic [BCD_W-1:0] min_units;
      logic [BCD_W-1:0] sec_tens;
      logic [BCD_W-1:0] sec_units;
      logic [BCD_W-1:0] cs_tens;
      logic [BCD_W-1:0] cs_units;
   } time_rec_t;

   // Modulus of digit position idx, 0 = cs_units .. 5 = min_tens.
   function automatic int digit_mod(input int idx);
      case (idx)
         0:       return CS_MOD;
         1:       return CS_MOD;
         3:       return SEC_TENS_MOD;
         5:       return MIN_TENS_MOD;
         default: return UNITS_MOD;
      endcase
   endfunction

endpackage

// File: rtl/bcd_digit_counter.sv
// One BCD digit of the elapsed-time chain, counting 0..MOD-1.
// Ports:
//   clk_i, reset_i  clock, asynchronous active-high reset
//   clr_i           synchronous clear to 0 (wins over inc_i)
//   inc_i           advance by one on this edge
//   digit_o         current digit value
//   carry_o         combinational: this edge rolls MOD-1 -> 0
module bcd_digit_counter
   import stopwatch_pkg::*;
#(
   parameter int MOD = 10
) (
   input  logic             clk_i,
   input  logic             reset_i,
   input  logic             clr_i,
   input  logic             inc_i,
   output logic [BCD_W-1:0] digit_o,
   output logic             carry_o
);

   localparam logic [BCD_W-1:0] LAST = BCD_W'(MOD - 1);

   logic [BCD_W-1:0] digit_q;

   always_ff @(posedge clk_i or posedge reset_i) begin
      if (reset_i)
         digit_q <= '0;
      else if (clr_i)
         digit_q <= '0;
      else if (inc_i)
         digit_q <= (digit_q == LAST) ? '0 : digit_q + BCD_W'(1);
   end

   assign digit_o = digit_q;
   assign carry_o = inc_i && (digit_q == LAST);

endmodule

// File: rtl/stopwatch_time_counter.sv
// Elapsed-time accumulator for the stopwatch. Divides clk_i down to a
// TICK_HZ timebase and counts MM:SS.cc in BCD up to 59:59.99, then wraps.
// Ports:
//   clk_i, reset_i      clock, asynchronous active-high reset
//   en_i                count enable (pauses prescaler and digits when low)
//   clr_i               synchronous clear of prescaler and digits
//   *_units_o/*_tens_o  BCD digits of the elapsed time
//   tick_o              1-cycle pulse after each centisecond increment
//   wrap_o              1-cycle pulse after 59:59.99 -> 00:00.00
// DIV = CLK_FREQ_HZ / TICK_HZ must be an integer >= 2.
module stopwatch_time_counter
   import stopwatch_pkg::*;
#(
   parameter int CLK_FREQ_HZ = 50_000_000,
   parameter int TICK_HZ     = 100
) (
   input  logic             clk_i,
   input  logic             reset_i,
   input  logic             en_i,
   input  logic             clr_i,
   output logic [BCD_W-1:0] cs_units_o,
   output logic [BCD_W-1:0] cs_tens_o,
   output logic [BCD_W-1:0] sec_units_o,
   output logic [BCD_W-1:0] sec_tens_o,
   output logic [BCD_W-1:0] min_units_o,
   output logic [BCD_W-1:0] min_tens_o,
   output logic             tick_o,
   output logic             wrap_o
);

   localparam int DIV  = CLK_FREQ_HZ / TICK_HZ;
   localparam int PS_W = (DIV > 1) ? $clog2(DIV) : 1;
   localparam logic [PS_W-1:0] PS_LAST = PS_W'(DIV - 1);

   logic [PS_W-1:0]                  ps_q;
   logic                             inc;
   logic [NUM_DIGITS:0]              inc_chain;
   logic [NUM_DIGITS-1:0][BCD_W-1:0] digits;
   time_rec_t                        time_now;
   logic                             tick_q;
   logic                             wrap_q;

   // Prescaler only moves on enabled cycles, so a pause keeps the partial
   // tick and resuming finishes it.
   always_ff @(posedge clk_i or posedge reset_i) begin
      if (reset_i)
         ps_q <= '0;
      else if (clr_i)
         ps_q <= '0;
      else if (en_i)
         ps_q <= (ps_q == PS_LAST) ? '0 : ps_q + PS_W'(1);
   end

   // Clear suppresses an increment that would land on the same edge.
   assign inc = en_i && !clr_i && (ps_q == PS_LAST);

   // Carries ripple combinationally so 59:59.99 -> 00:00.00 settles in one edge.
   assign inc_chain[0] = inc;
   for (genvar g = 0; g < NUM_DIGITS; g++) begin : g_digit
      bcd_digit_counter #(.MOD(digit_mod(g))) u_digit (
         .clk_i   (clk_i),
         .reset_i (reset_i),
         .clr_i   (clr_i),
         .inc_i   (inc_chain[g]),
         .digit_o (digits[g]),
         .carry_o (inc_chain[g+1])
      );
   end

   always_ff @(posedge clk_i or posedge reset_i) begin
      if (reset_i) begin
         tick_q <= 1'b0;
         wrap_q <= 1'b0;
      end else if (clr_i) begin
         tick_q <= 1'b0;
         wrap_q <= 1'b0;
      end else begin
         tick_q <= inc;
         wrap_q <= inc_chain[NUM_DIGITS];
      end
   end

   assign time_now    = time_rec_t'(digits);
   assign cs_units_o  = time_now.cs_units;
   assign cs_tens_o   = time_now.cs_tens;
   assign sec_units_o = time_now.sec_units;
   assign sec_tens_o  = time_now.sec_tens;
   assign min_units_o = time_now.min_units;
   assign min_tens_o  = time_now.min_tens;
   assign tick_o      = tick_q;
   assign wrap_o      = wrap_q;

endmodule
